// File: rtl/spi_csr_bridge_if.sv
// CPU load/store bus between a bus master and the SPI CSR bridge.
//
// Handshake: bus_rd / bus_wr are single-cycle request strobes, sampled at
// every clock edge. No backpressure exists, so a request is always taken.
// bus_ack is a one-cycle response in the cycle after the request, and
// bus_rdata is meaningful only while bus_ack is high. A request can be
// issued every cycle, and each request is acknowledged exactly once.
interface spi_csr_bridge_if;
  logic [3:0]  bus_addr;
  logic        bus_rd;
  logic        bus_wr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  modport master (
    output bus_addr, bus_rd, bus_wr, bus_wdata,
    input  bus_rdata, bus_ack
  );

  modport slave (
    input  bus_addr, bus_rd, bus_wr, bus_wdata,
    output bus_rdata, bus_ack
  );
endinterface

// File: rtl/spi_csr_bridge.sv
// SPI CSR bridge: buffers received SPI bytes in an RX FIFO and exposes
// STATUS/RXDATA/TXDATA/CTRL registers on a single-cycle load/store bus.
// It drives bytes back to the SPI front end and raises a level interrupt
// when RX data is pending or an overflow has occurred.
module spi_csr_bridge #(
  parameter int RX_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [7:0]             rx_buff,
  input  logic                   rx_valid,
  input  logic                   mode,
  input  logic                   cmd_error,
  output logic [7:0]             tx_buff,
  output logic                   tx_valid,
  spi_csr_bridge_if.slave        bus,
  output logic                   irq
);

  localparam int AW = $clog2(RX_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [1:0] REG_STATUS = 2'd0;
  localparam logic [1:0] REG_RXDATA = 2'd1;
  localparam logic [1:0] REG_TXDATA = 2'd2;
  localparam logic [1:0] REG_CTRL   = 2'd3;

  logic [7:0]    mem [RX_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          ovf;
  logic          irq_en;

  logic [1:0]    sel;
  logic          rd_req;
  logic          wr_req;
  logic          empty;
  logic          full;
  logic          pop;
  logic          push;
  logic          ovf_set;
  logic          ovf_clr;
  logic [7:0]    head;
  logic [7:0]    count_byte;
  logic [31:0]   rd_data;

  // Request decode and FIFO control. A read wins over a simultaneous write.
  // A pop frees a slot in the same cycle, so a full FIFO can still accept a push.
  always_comb begin
    sel        = bus.bus_addr[3:2];
    rd_req     = bus.bus_rd;
    wr_req     = bus.bus_wr & ~bus.bus_rd;
    empty      = (count == '0);
    full       = (count == CW'(RX_DEPTH));
    pop        = rd_req && (sel == REG_RXDATA) && !empty;
    push       = rx_valid && (!full || pop);
    ovf_set    = rx_valid && full && !pop;
    ovf_clr    = wr_req && (sel == REG_CTRL) && bus.bus_wdata[1];
    head       = mem[rd_ptr];
    count_byte = 8'(count);
  end

  // Read data mux. This reflects the state before any side effect of this request.
  always_comb begin
    rd_data = 32'h0;
    case (sel)
      REG_STATUS: rd_data = {16'h0, count_byte, 3'b0, cmd_error, mode, ovf, full, ~empty};
      REG_RXDATA: rd_data = empty ? 32'h0000_0100 : {24'h0, head};
      REG_TXDATA: rd_data = 32'h0;
      REG_CTRL:   rd_data = {31'h0, irq_en};
      default:    rd_data = 32'h0;
    endcase
  end

  // FIFO storage. The contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= rx_buff;
  end

  // FIFO pointers, occupancy and the sticky overflow flag (set wins over clear).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
      ovf   <= ovf_set | (ovf & ~ovf_clr);
    end
  end

  // Control register, bus response and TX strobe. All are registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_en        <= 1'b0;
      bus.bus_ack   <= 1'b0;
      bus.bus_rdata <= 32'h0;
      tx_buff       <= 8'h0;
      tx_valid      <= 1'b0;
    end else begin
      if (wr_req && (sel == REG_CTRL)) irq_en <= bus.bus_wdata[0];
      bus.bus_ack   <= rd_req | wr_req;
      bus.bus_rdata <= rd_req ? rd_data : 32'h0;
      tx_valid      <= wr_req && (sel == REG_TXDATA);
      if (wr_req && (sel == REG_TXDATA)) tx_buff <= bus.bus_wdata[7:0];
    end
  end

  // Interrupt level. This is computed from registered state, so it lags the triggering event by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq <= 1'b0;
    else        irq <= irq_en & (~empty | ovf);
  end

endmodule
